// File: rtl/stage_4_mem_pkg.sv
// stage_4_mem_pkg: shared FSM states, opcode/func_3 codes and store-side helpers for the memory stage.
package stage_4_mem_pkg;
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_e;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  function automatic logic mem_ok(input logic st, input logic [2:0] f3, input logic [1:0] a);
    logic legal;
    logic aligned;
    legal = st ? (f3 == F3_SB || f3 == F3_SH || f3 == F3_SW)
               : (f3 == F3_LB || f3 == F3_LH || f3 == F3_LW || f3 == F3_LBU || f3 == F3_LHU);
    aligned = (f3[1:0] == 2'b01) ? !a[0] : (f3[1:0] == 2'b10) ? (a == 2'b00) : 1'b1;
    return legal && aligned;
  endfunction

  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] a);
    return (f3 == F3_SB) ? 4'b0001 << a : (f3 == F3_SH) ? 4'b0011 << {a[1], 1'b0} : 4'b1111;
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] rs2);
    return (f3 == F3_SB) ? {4{rs2[7:0]}} : (f3 == F3_SH) ? {2{rs2[15:0]}} : rs2;
  endfunction
endpackage

// File: rtl/stage_4_mem_load_align.sv
// mem_load_align: picks the addressed byte/half/word of a read word and sign- or zero-extends it.
module mem_load_align
  import stage_4_mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  func_3,
  output logic [31:0] data
);
  logic [31:0] sh;
  always_comb begin
    sh = rdata >> {addr_lo, 3'b000};
    data = (func_3 == F3_LB)  ? {{24{sh[7]}}, sh[7:0]} :
           (func_3 == F3_LH)  ? {{16{sh[15]}}, sh[15:0]} :
           (func_3 == F3_LBU) ? {24'b0, sh[7:0]} :
           (func_3 == F3_LHU) ? {16'b0, sh[15:0]} : rdata;
  end
endmodule

// File: rtl/stage_4_mem.sv
// stage_4_mem: RV32I memory stage; passes ALU results through and runs req/gnt/rvalid loads and stores.
module stage_4_mem
  import stage_4_mem_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [31:0] i_alu_out,
  input  logic [31:0] i_rs_2,
  input  logic [4:0]  i_rd_num,
  input  logic [6:0]  i_opcode,
  input  logic [2:0]  i_func_3,
  input  logic        i_op_type,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        o_valid,
  output logic [4:0]  o_rd_num,
  output logic [31:0] o_wb_data,
  output logic        o_wb_en,
  output logic        o_fault
);
  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, wb_data_q, wb_data_d;
  logic [3:0]  be_q, be_d;
  logic        we_q, we_d, valid_q, valid_d, wb_en_q, wb_en_d, fault_q, fault_d;
  logic [4:0]  rd_q, rd_d, o_rd_q, o_rd_d;
  logic [2:0]  f3_q, f3_d;
  logic [31:0] load_val;
  logic        is_store;

  mem_load_align u_align (
    .rdata   (dmem_rdata),
    .addr_lo (addr_q[1:0]),
    .func_3  (f3_q),
    .data    (load_val)
  );

  assign is_store   = (i_opcode == OP_STORE);
  assign o_ready    = (state_q == S_IDLE);
  assign dmem_req   = (state_q == S_REQ);
  assign dmem_we    = we_q;
  assign dmem_addr  = {addr_q[31:2], 2'b00};
  assign dmem_be    = be_q;
  assign dmem_wdata = wdata_q;
  assign o_valid    = valid_q;
  assign o_rd_num   = o_rd_q;
  assign o_wb_data  = wb_data_q;
  assign o_wb_en    = wb_en_q;
  assign o_fault    = fault_q;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    we_d      = we_q;
    rd_d      = rd_q;
    f3_d      = f3_q;
    o_rd_d    = o_rd_q;
    wb_data_d = wb_data_q;
    valid_d   = 1'b0;
    wb_en_d   = 1'b0;
    fault_d   = 1'b0;
    if (state_q == S_IDLE && i_valid && !i_op_type) begin
      valid_d   = 1'b1;
      o_rd_d    = i_rd_num;
      wb_data_d = i_alu_out;
      wb_en_d   = (i_rd_num != 5'd0) && (i_opcode != OP_BRANCH) && (i_opcode != OP_STORE);
    end else if (state_q == S_IDLE && i_valid) begin
      addr_d  = i_alu_out;
      wdata_d = store_data(i_func_3, i_rs_2);
      be_d    = is_store ? store_be(i_func_3, i_alu_out[1:0]) : 4'b1111;
      we_d    = is_store;
      rd_d    = i_rd_num;
      f3_d    = i_func_3;
      state_d = mem_ok(is_store, i_func_3, i_alu_out[1:0]) ? S_REQ : S_IDLE;
      valid_d = !mem_ok(is_store, i_func_3, i_alu_out[1:0]);
      fault_d = valid_d;
      o_rd_d  = valid_d ? i_rd_num : o_rd_q;
    end else if (state_q == S_REQ && dmem_gnt) begin
      state_d = we_q ? S_IDLE : S_WAIT;
      valid_d = we_q;
      o_rd_d  = we_q ? rd_q : o_rd_q;
    end else if (state_q == S_WAIT && dmem_rvalid) begin
      state_d   = S_IDLE;
      valid_d   = 1'b1;
      o_rd_d    = rd_q;
      wb_data_d = load_val;
      wb_en_d   = (rd_q != 5'd0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      we_q      <= 1'b0;
      rd_q      <= '0;
      f3_q      <= '0;
      o_rd_q    <= '0;
      wb_data_q <= '0;
      valid_q   <= 1'b0;
      wb_en_q   <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      we_q      <= we_d;
      rd_q      <= rd_d;
      f3_q      <= f3_d;
      o_rd_q    <= o_rd_d;
      wb_data_q <= wb_data_d;
      valid_q   <= valid_d;
      wb_en_q   <= wb_en_d;
      fault_q   <= fault_d;
    end
  end
endmodule

// File: tb/tb_stage_4_mem.sv
// tb_stage_4_mem: randomized scenario tasks checked against an arithmetic model of the memory stage.
module tb_stage_4_mem;
  localparam logic [6:0] LOAD = 7'b0000011, STORE = 7'b0100011, BRANCH = 7'b1100011;
  logic clk = 0, rst_n = 0;
  logic i_valid = 0, i_op_type = 0, dmem_gnt = 0, dmem_rvalid = 0;
  logic [31:0] i_alu_out = 0, i_rs_2 = 0, dmem_rdata = 0;
  logic [4:0] i_rd_num = 0;
  logic [6:0] i_opcode = 0;
  logic [2:0] i_func_3 = 0;
  logic o_ready, dmem_req, dmem_we, o_valid, o_wb_en, o_fault;
  logic [31:0] dmem_addr, dmem_wdata, o_wb_data;
  logic [3:0] dmem_be;
  logic [4:0] o_rd_num;
  int errors = 0, checks = 0;

  stage_4_mem dut (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_alu_out(i_alu_out), .i_rs_2(i_rs_2), .i_rd_num(i_rd_num), .i_opcode(i_opcode),
    .i_func_3(i_func_3), .i_op_type(i_op_type), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata), .o_valid(o_valid), .o_rd_num(o_rd_num),
    .o_wb_data(o_wb_data), .o_wb_en(o_wb_en), .o_fault(o_fault)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic int unsigned msize(input logic [2:0] f3);
    return (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit m_ok(input bit st, input logic [2:0] f3, input logic [31:0] addr);
    bit legal;
    legal = st ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    return legal && (addr % msize(f3) == 0);
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] addr);
    logic [3:0] be = 0;
    for (int i = 0; i < msize(f3); i++) be[addr % 4 + i] = 1'b1;
    return be;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] rs2);
    logic [31:0] w;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = rs2[8*(i % msize(f3)) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rdata);
    longint unsigned v, lim;
    v = rdata >> (8 * (addr % 4));
    if (msize(f3) == 4) return rdata;
    lim = 64'd1 << (8 * msize(f3));
    v = v % lim;
    if (!f3[2] && v >= lim / 2) v = v + 64'h1_0000_0000 - lim;
    return v[31:0];
  endfunction

  task automatic do_alu(input logic [6:0] op, input logic [31:0] val, input logic [4:0] rd);
    bit en;
    en = (rd != 0) && op != BRANCH && op != STORE;
    i_valid = 1; i_op_type = 0; i_opcode = op; i_alu_out = val; i_rd_num = rd;
    tick;
    i_valid = 0; i_alu_out = $urandom;
    checks++;
    if ({o_valid, o_wb_en, o_fault, o_ready, dmem_req, o_rd_num, o_wb_data} !== {1'b1, en, 1'b0, 1'b1, 1'b0, rd, val})
      begin errors++; $display("FAIL alu: got v=%b en=%b f=%b rdy=%b req=%b rd=%0d d=%h want en=%b rd=%0d d=%h",
        o_valid, o_wb_en, o_fault, o_ready, dmem_req, o_rd_num, o_wb_data, en, rd, val); end
  endtask

  task automatic do_mem(input bit st, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rs2,
                        input logic [31:0] rdata, input logic [4:0] rd, input int gd, input int rvd);
    logic [31:0] exp;
    i_valid = 1; i_op_type = 1; i_opcode = st ? STORE : LOAD; i_func_3 = f3;
    i_alu_out = addr; i_rs_2 = rs2; i_rd_num = rd;
    checks++;
    if (o_ready !== 1'b1) begin errors++; $display("FAIL ready_idle: got %b want 1", o_ready); end
    tick;
    i_valid = 0; i_alu_out = $urandom; i_rs_2 = $urandom; i_func_3 = $urandom;
    if (!m_ok(st, f3, addr)) begin
      checks++;
      if ({dmem_req, o_valid, o_fault, o_wb_en, o_ready} !== 5'b01101)
        begin errors++; $display("FAIL fault: got req=%b v=%b f=%b en=%b rdy=%b want 0 1 1 0 1",
          dmem_req, o_valid, o_fault, o_wb_en, o_ready); end
      return;
    end
    checks++;
    if ({dmem_req, o_ready, o_valid, dmem_we, dmem_addr} !== {3'b100, st, addr & 32'hFFFF_FFFC})
      begin errors++; $display("FAIL req: got req=%b rdy=%b v=%b we=%b a=%h want we=%b a=%h",
        dmem_req, o_ready, o_valid, dmem_we, dmem_addr, st, addr & 32'hFFFF_FFFC); end
    if (st) begin
      checks++;
      if ({dmem_be, dmem_wdata} !== {m_be(f3, addr), m_wdata(f3, rs2)})
        begin errors++; $display("FAIL store_lanes: got be=%b wd=%h want be=%b wd=%h",
          dmem_be, dmem_wdata, m_be(f3, addr), m_wdata(f3, rs2)); end
    end
    repeat (gd) begin
      tick;
      checks++;
      if ({dmem_req, o_ready, o_valid} !== 3'b100 || dmem_addr !== (addr & 32'hFFFF_FFFC))
        begin errors++; $display("FAIL req_hold: got req=%b rdy=%b v=%b a=%h", dmem_req, o_ready, o_valid, dmem_addr); end
    end
    dmem_gnt = 1;
    tick;
    dmem_gnt = 0;
    if (st) begin
      checks++;
      if ({o_valid, o_wb_en, o_fault, dmem_req, o_ready} !== 5'b10001)
        begin errors++; $display("FAIL store_done: got v=%b en=%b f=%b req=%b rdy=%b want 1 0 0 0 1",
          o_valid, o_wb_en, o_fault, dmem_req, o_ready); end
      return;
    end
    checks++;
    if ({o_valid, dmem_req, o_ready} !== 3'b000)
      begin errors++; $display("FAIL wait: got v=%b req=%b rdy=%b want 000", o_valid, dmem_req, o_ready); end
    repeat (rvd) tick;
    dmem_rvalid = 1; dmem_rdata = rdata;
    tick;
    dmem_rvalid = 0; dmem_rdata = $urandom;
    exp = m_load(f3, addr, rdata);
    checks++;
    if ({o_valid, o_wb_en, o_fault, o_ready, o_rd_num, o_wb_data} !== {1'b1, rd != 0, 1'b0, 1'b1, rd, exp})
      begin errors++; $display("FAIL load: got v=%b en=%b f=%b rdy=%b rd=%0d d=%h want en=%b rd=%0d d=%h",
        o_valid, o_wb_en, o_fault, o_ready, o_rd_num, o_wb_data, rd != 0, rd, exp); end
    tick;
    checks++;
    if (o_valid !== 1'b0) begin errors++; $display("FAIL pulse: got o_valid=%b want 0", o_valid); end
  endtask

  task automatic test_reset;
    rst_n = 0;
    tick; tick;
    checks++;
    if ({o_valid, o_wb_en, o_fault, dmem_req, dmem_we, dmem_be, o_rd_num, o_wb_data, dmem_addr, dmem_wdata, o_ready} !== {110'b0, 1'b1})
      begin errors++; $display("FAIL reset: got v=%b en=%b f=%b req=%b we=%b be=%b rd=%0d d=%h a=%h wd=%h rdy=%b",
        o_valid, o_wb_en, o_fault, dmem_req, dmem_we, dmem_be, o_rd_num, o_wb_data, dmem_addr, dmem_wdata, o_ready); end
    rst_n = 1;
    tick;
  endtask

  task automatic test_alu;
    logic [6:0] ops [4] = '{7'b0010011, 7'b0110011, BRANCH, STORE};
    do_alu(7'b0010011, 32'h42, 5'd5);
    for (int i = 0; i < 12; i++) do_alu(ops[$urandom_range(3)], $urandom, 5'($urandom_range(31)));
  endtask

  task automatic test_back_to_back;
    logic [31:0] v;
    logic [4:0] rd;
    i_valid = 1; i_op_type = 0; i_opcode = 7'b0110111;
    for (int i = 0; i < 16; i++) begin
      v = $urandom; rd = 5'($urandom_range(31));
      i_alu_out = v; i_rd_num = rd;
      tick;
      checks++;
      if ({o_valid, o_wb_en, o_ready, o_rd_num, o_wb_data} !== {1'b1, rd != 0, 1'b1, rd, v})
        begin errors++; $display("FAIL b2b: got v=%b en=%b rdy=%b rd=%0d d=%h want rd=%0d d=%h",
          o_valid, o_wb_en, o_ready, o_rd_num, o_wb_data, rd, v); end
    end
    i_valid = 0;
    tick;
  endtask

  task automatic test_directed_mem;
    do_mem(0, 3'b000, 32'h1003, 32'h0, 32'h80FF_FF7F, 5'd7, 2, 0);
    do_mem(1, 3'b001, 32'h2002, 32'h1234_ABCD, 32'h0, 5'd3, 1, 0);
    do_mem(0, 3'b010, 32'h1001, 32'h0, 32'h0, 5'd4, 0, 0);
    do_mem(0, 3'b101, 32'h0002, 32'h0, 32'hF00D_0000, 5'd0, 0, 1);
    do_mem(1, 3'b100, 32'h3000, 32'h5, 32'h0, 5'd1, 0, 0);
  endtask

  task automatic test_random_mem;
    for (int i = 0; i < 60; i++)
      do_mem(1'($urandom_range(1)), 3'($urandom_range(7)), $urandom, $urandom, $urandom,
             5'($urandom_range(31)), $urandom_range(3), $urandom_range(2));
  endtask

  task automatic test_stray_rvalid;
    dmem_rvalid = 1; dmem_rdata = $urandom;
    tick; tick;
    dmem_rvalid = 0;
    checks++;
    if ({o_valid, dmem_req, o_ready} !== 3'b001)
      begin errors++; $display("FAIL stray_rvalid: got v=%b req=%b rdy=%b want 001", o_valid, dmem_req, o_ready); end
  endtask

  task automatic test_reset_mid;
    i_valid = 1; i_op_type = 1; i_opcode = LOAD; i_func_3 = 3'b010; i_alu_out = 32'h40; i_rd_num = 5'd9;
    tick;
    i_valid = 0; dmem_gnt = 1;
    tick;
    dmem_gnt = 0;
    #2 rst_n = 0;
    #1;
    checks++;
    if ({dmem_req, o_ready, o_valid} !== 3'b010)
      begin errors++; $display("FAIL async_reset: got req=%b rdy=%b v=%b want 010", dmem_req, o_ready, o_valid); end
    tick;
    rst_n = 1; dmem_rvalid = 1; dmem_rdata = 32'hDEAD_BEEF;
    tick;
    dmem_rvalid = 0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({o_valid, dmem_req, o_ready} !== 3'b001)
        begin errors++; $display("FAIL stale_rvalid: got v=%b req=%b rdy=%b want 001", o_valid, dmem_req, o_ready); end
      tick;
    end
    do_alu(7'b0010011, 32'h1234_5678, 5'd2);
  endtask

  initial begin
    test_reset;
    test_alu;
    test_back_to_back;
    test_directed_mem;
    test_random_mem;
    test_stray_rvalid;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
